// File: rtl/eth_rx_parser.sv
// ----------------------------------------------------------------------------
// eth_rx_parser
//
// GMII receive-side frame parser. Tracks preamble/SFD, then runs over the frame
// body (destination MAC through FCS) checking the destination address, capturing
// the source MAC and EtherType, counting bytes and checking the CRC-32 residue.
// When rx_dv drops at the end of the body the frame is judged and either a
// good-frame pulse (only for frames addressed to this station or broadcast) or
// an error pulse is issued on the following cycle.
//
// Ports:
//   rx_clk        in   receive byte clock, rising edge
//   rst_n         in   synchronous active-low reset
//   rx_dv         in   GMII receive data valid
//   rxd[7:0]      in   GMII receive byte
//   ip_pkt_end    out  one-cycle pulse: good frame for this station ended
//   ip_prot_type  out  EtherType of current/last frame (byte 12 in [15:8])
//   src_mac       out  source MAC of current/last frame (byte 6 in [47:40])
//   frame_err     out  one-cycle pulse: frame dropped (CRC, length, bad SFD)
// ----------------------------------------------------------------------------
module eth_rx_parser #(
    parameter logic [47:0] LOCAL_MAC = 48'h000a35028846,
    parameter int unsigned MIN_LEN   = 64,
    parameter int unsigned MAX_LEN   = 1518
) (
    input  logic        rx_clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic [7:0]  rxd,
    output logic        ip_pkt_end,
    output logic [15:0] ip_prot_type,
    output logic [47:0] src_mac,
    output logic        frame_err
);

    localparam logic [10:0] MinLen     = 11'(MIN_LEN);
    localparam logic [10:0] MaxLen     = 11'(MAX_LEN);
    localparam logic [10:0] CntMax     = 11'h7ff;
    localparam logic [31:0] CrcInit    = 32'hffffffff;
    localparam logic [31:0] CrcResidue = 32'hc704dd7b;
    localparam logic [7:0]  Preamble   = 8'h55;
    localparam logic [7:0]  Sfd        = 8'hd5;
    localparam logic [2:0]  MaxPreCnt  = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StBody,
        StDrop
    } state_e;

    state_e      state_q;
    logic [2:0]  pre_cnt_q;
    logic [10:0] byte_cnt_q;
    logic [31:0] crc_q;
    logic        local_hit_q;
    logic        bcast_hit_q;
    logic        abort_q;
    logic        ip_pkt_end_q;
    logic        frame_err_q;
    logic [15:0] prot_q;
    logic [47:0] src_q;

    // CRC-32, polynomial 0x04C11DB7. Data bits enter LSB first (reflected input)
    // while the register shifts MSB first, so the register holds the bit-reversed
    // form of the classic reflected CRC and the good-frame residue is C704DD7B.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[31] ^ d[i]) begin
                c = {c[30:0], 1'b0} ^ 32'h04c11db7;
            end else begin
                c = {c[30:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [7:0]  local_byte;
    logic [10:0] byte_cnt_inc;
    logic        len_ok;
    logic        crc_ok;
    logic        frame_good;
    logic        dst_ok;

    // Byte of LOCAL_MAC expected at the current destination position.
    always_comb begin
        local_byte = 8'h00;
        case (byte_cnt_q)
            11'd0:   local_byte = LOCAL_MAC[47:40];
            11'd1:   local_byte = LOCAL_MAC[39:32];
            11'd2:   local_byte = LOCAL_MAC[31:24];
            11'd3:   local_byte = LOCAL_MAC[23:16];
            11'd4:   local_byte = LOCAL_MAC[15:8];
            11'd5:   local_byte = LOCAL_MAC[7:0];
            default: local_byte = 8'h00;
        endcase
    end

    always_comb begin
        byte_cnt_inc = (byte_cnt_q == CntMax) ? byte_cnt_q : byte_cnt_q + 11'd1;
        len_ok       = (byte_cnt_q >= MinLen) && (byte_cnt_q <= MaxLen);
        crc_ok       = (crc_q == CrcResidue);
        frame_good   = crc_ok && len_ok;
        // Hit flags start set at SFD, so a full destination must have been seen.
        dst_ok       = (local_hit_q || bcast_hit_q) && (byte_cnt_q >= 11'd6);
    end

    always_ff @(posedge rx_clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pre_cnt_q    <= 3'd0;
            byte_cnt_q   <= 11'd0;
            crc_q        <= CrcInit;
            local_hit_q  <= 1'b0;
            bcast_hit_q  <= 1'b0;
            // A frame interrupted by reset must be skipped until rx_dv falls.
            abort_q      <= 1'b1;
            ip_pkt_end_q <= 1'b0;
            frame_err_q  <= 1'b0;
            prot_q       <= 16'h0000;
            src_q        <= 48'h0;
        end else begin
            ip_pkt_end_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (!rx_dv) begin
                abort_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (rx_dv) begin
                        if (rxd == Preamble && !abort_q) begin
                            state_q   <= StPreamble;
                            pre_cnt_q <= 3'd1;
                        end else begin
                            state_q <= StDrop;
                        end
                    end
                end

                StPreamble: begin
                    if (!rx_dv) begin
                        state_q <= StIdle;
                    end else if (rxd == Preamble) begin
                        if (pre_cnt_q == MaxPreCnt) begin
                            state_q     <= StDrop;
                            frame_err_q <= 1'b1;
                        end else begin
                            pre_cnt_q <= pre_cnt_q + 3'd1;
                        end
                    end else if (rxd == Sfd) begin
                        state_q     <= StBody;
                        byte_cnt_q  <= 11'd0;
                        crc_q       <= CrcInit;
                        local_hit_q <= 1'b1;
                        bcast_hit_q <= 1'b1;
                    end else begin
                        state_q     <= StDrop;
                        frame_err_q <= 1'b1;
                    end
                end

                StBody: begin
                    if (rx_dv) begin
                        byte_cnt_q <= byte_cnt_inc;
                        crc_q      <= crc32_byte(crc_q, rxd);
                        if (byte_cnt_q < 11'd6) begin
                            if (rxd != local_byte) begin
                                local_hit_q <= 1'b0;
                            end
                            if (rxd != 8'hff) begin
                                bcast_hit_q <= 1'b0;
                            end
                        end
                        if (byte_cnt_q >= 11'd6 && byte_cnt_q < 11'd12) begin
                            src_q <= {src_q[39:0], rxd};
                        end
                        if (byte_cnt_q >= 11'd12 && byte_cnt_q < 11'd14) begin
                            prot_q <= {prot_q[7:0], rxd};
                        end
                    end else begin
                        // End of frame: judge with the registers covering every byte.
                        state_q <= StIdle;
                        if (frame_good) begin
                            ip_pkt_end_q <= dst_ok;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end

                StDrop: begin
                    if (!rx_dv) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign ip_pkt_end   = ip_pkt_end_q;
    assign frame_err    = frame_err_q;
    assign ip_prot_type = prot_q;
    assign src_mac      = src_q;

endmodule

// File: tb/tb_eth_rx_parser.sv
// ----------------------------------------------------------------------------
// tb_eth_rx_parser
//
// Scoreboard bench for eth_rx_parser. Stimulus builds frames as byte queues,
// appends a standard Ethernet FCS and predicts the outcome from the frame
// contents (FCS match, length window, destination class), pushing expected
// pulses with their cycle into a queue. A monitor pops and compares whenever
// the DUT pulses, and flags pulses that never arrive.
// ----------------------------------------------------------------------------
module tb_eth_rx_parser;

    localparam logic [47:0] LOCAL_MAC = 48'h000a35028846;
    localparam int unsigned MIN_LEN   = 64;
    localparam int unsigned MAX_LEN   = 1518;
    localparam logic [47:0] BCAST     = 48'hffffffffffff;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        bit          is_pkt;
        longint      at;
        logic [15:0] prot;
        logic [47:0] src;
    } ev_t;

    logic        rx_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        rx_dv  = 1'b0;
    logic [7:0]  rxd    = 8'h00;
    logic        ip_pkt_end;
    logic [15:0] ip_prot_type;
    logic [47:0] src_mac;
    logic        frame_err;

    int     n_vec  = 0;
    int     n_miss = 0;
    longint cyc    = 0;
    bit     mon_en = 1'b0;
    ev_t    exp_q[$];
    ev_t    mev;

    eth_rx_parser #(
        .LOCAL_MAC (LOCAL_MAC),
        .MIN_LEN   (MIN_LEN),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .rx_clk       (rx_clk),
        .rst_n        (rst_n),
        .rx_dv        (rx_dv),
        .rxd          (rxd),
        .ip_pkt_end   (ip_pkt_end),
        .ip_prot_type (ip_prot_type),
        .src_mac      (src_mac),
        .frame_err    (frame_err)
    );

    always #5 rx_clk = ~rx_clk;

    always @(posedge rx_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Standard reflected CRC-32 as used for the Ethernet FCS (complemented).
    function automatic logic [31:0] fcs32(input bq_t f, input int n);
        logic [31:0] c;
        c = 32'hffffffff;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, f[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic bq_t build_frame(input logic [47:0] dst, input logic [47:0] src,
                                        input logic [15:0] etype, input int paylen);
        bq_t f;
        logic [31:0] fcs;
        f = {};
        for (int i = 5; i >= 0; i--) f.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(src[8*i +: 8]);
        f.push_back(etype[15:8]);
        f.push_back(etype[7:0]);
        for (int i = 0; i < paylen; i++) f.push_back(8'($urandom));
        fcs = fcs32(f, f.size());
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        return f;
    endfunction

    // Predict the frame outcome from its bytes and queue the expected pulse.
    task automatic expect_frame(input bq_t f, input longint last_cyc);
        int          len;
        logic [31:0] rx_fcs;
        logic [47:0] dst;
        bit          good;
        bit          dst_ok;
        ev_t         e;
        len    = f.size();
        rx_fcs = {f[len-1], f[len-2], f[len-3], f[len-4]};
        dst    = {f[0], f[1], f[2], f[3], f[4], f[5]};
        good   = (fcs32(f, len - 4) == rx_fcs) && (len >= MIN_LEN) && (len <= MAX_LEN);
        dst_ok = (dst == LOCAL_MAC) || (dst == BCAST);
        e.at   = last_cyc + 2;
        e.prot = {f[12], f[13]};
        e.src  = {f[6], f[7], f[8], f[9], f[10], f[11]};
        if (good && dst_ok) begin
            e.is_pkt = 1'b1;
            exp_q.push_back(e);
        end else if (!good) begin
            e.is_pkt = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_err(input longint at);
        ev_t e;
        e.is_pkt = 1'b0;
        e.at     = at;
        e.prot   = 16'h0;
        e.src    = 48'h0;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic dv, input logic [7:0] d);
        @(posedge rx_clk);
        #1;
        rx_dv = dv;
        rxd   = d;
    endtask

    task automatic send_frame(input bq_t f, input int npre, input int gap);
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
        drive(1'b1, 8'hd5);
        foreach (f[i]) drive(1'b1, f[i]);
        expect_frame(f, cyc);
        for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
    endtask

    // Monitor: compares every pulse against the head of the expectation queue.
    always @(negedge rx_clk) begin
        if (mon_en) begin
            if (ip_pkt_end || frame_err) begin
                check("pulse_exclusive", 64'(ip_pkt_end & frame_err), 64'd0);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_pulse: got pkt_end=%b frame_err=%b at cycle %0d, expected none",
                             ip_pkt_end, frame_err, cyc);
                end else begin
                    mev = exp_q.pop_front();
                    check("pulse_kind", 64'(ip_pkt_end), 64'(mev.is_pkt));
                    check("pulse_cycle", 64'(cyc), 64'(mev.at));
                    if (mev.is_pkt) begin
                        check("ip_prot_type", 64'(ip_prot_type), 64'(mev.prot));
                        check("src_mac", 64'(src_mac), 64'(mev.src));
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                mev = exp_q.pop_front();
                n_vec++;
                n_miss++;
                $display("FAIL missing_pulse: got none by cycle %0d, expected %s at cycle %0d",
                         cyc, mev.is_pkt ? "ip_pkt_end" : "frame_err", mev.at);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t         f;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        int          idx;

        // Reset state.
        repeat (3) drive(1'b0, 8'h00);
        @(negedge rx_clk);
        check("rst_pkt_end", 64'(ip_pkt_end), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_prot", 64'(ip_prot_type), 64'd0);
        check("rst_src", 64'(src_mac), 64'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) drive(1'b0, 8'h00);

        // Broadcast ARP, minimum length.
        f = build_frame(BCAST, 48'h021234567 << 4, 16'h0806, 46);
        send_frame(f, 7, 1);

        // Same frame with one payload bit flipped.
        f[20] = f[20] ^ 8'h10;
        send_frame(f, 7, 1);

        // Valid frame to another station: no pulse, fields still captured.
        f = build_frame(48'h001122334455, 48'h0a0b0c0d0e0f, 16'h0800, 46);
        send_frame(f, 7, 2);
        check("other_dst_prot", 64'(ip_prot_type), 64'h0800);
        check("other_dst_src", 64'(src_mac), 64'h0a0b0c0d0e0f);

        // Length boundaries: 60 (short), 1518 (max), 1519 (long).
        f = build_frame(LOCAL_MAC, 48'h111111111111, 16'h86dd, 42);
        send_frame(f, 7, 1);
        f = build_frame(LOCAL_MAC, 48'h222222222222, 16'h0800, 1500);
        send_frame(f, 7, 1);
        f = build_frame(LOCAL_MAC, 48'h333333333333, 16'h0800, 1501);
        send_frame(f, 7, 1);

        // Bad SFD: 55,55,aa then junk, one idle cycle, then a good frame.
        drive(1'b1, 8'h55);
        drive(1'b1, 8'h55);
        drive(1'b1, 8'haa);
        push_err(cyc + 1);
        repeat (10) drive(1'b1, 8'($urandom));
        drive(1'b0, 8'h00);
        f = build_frame(LOCAL_MAC, 48'h444444444444, 16'h0806, 50);
        send_frame(f, 7, 1);

        // Overlong preamble: eight 0x55 before SFD.
        for (int i = 0; i < 8; i++) drive(1'b1, 8'h55);
        push_err(cyc + 1);
        drive(1'b1, 8'hd5);
        f = build_frame(LOCAL_MAC, 48'h555555555555, 16'h0800, 46);
        foreach (f[i]) drive(1'b1, f[i]);
        drive(1'b0, 8'h00);

        // One-cycle reset at byte 20 of a valid frame.
        f = build_frame(LOCAL_MAC, 48'h666666666666, 16'h0800, 60);
        repeat (7) drive(1'b1, 8'h55);
        drive(1'b1, 8'hd5);
        foreach (f[i]) begin
            drive(1'b1, f[i]);
            rst_n = (i != 20);
        end
        repeat (2) drive(1'b0, 8'h00);
        check("reset_abort_src", 64'(src_mac), 64'd0);
        check("reset_abort_prot", 64'(ip_prot_type), 64'd0);
        f = build_frame(LOCAL_MAC, 48'h777777777777, 16'h0806, 46);
        send_frame(f, 7, 1);

        // Randomized traffic, back-to-back with short gaps.
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 2))
                0:       dst = LOCAL_MAC;
                1:       dst = BCAST;
                default: dst = {16'h0200, 32'($urandom)};
            endcase
            src = {16'($urandom), 32'($urandom)};
            et  = 16'($urandom);
            f   = build_frame(dst, src, et, int'($urandom_range(40, 120)));
            if ($urandom_range(0, 3) == 0) begin
                idx    = int'($urandom_range(0, f.size() - 1));
                f[idx] = f[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
            send_frame(f, int'($urandom_range(1, 7)), int'($urandom_range(1, 3)));
        end

        repeat (5) drive(1'b0, 8'h00);
        check("pending_events", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/eth_rx_parser.md
ETH_RX_PARSER -- requirements
Module: eth_rx_parser

Interface
REQ-001 Parameter LOCAL_MAC, default 48'h000a35028846, station MAC address accepted as destination.
REQ-002 Parameter MIN_LEN, default 64, minimum accepted frame length in bytes (dst MAC through FCS).
REQ-003 Parameter MAX_LEN, default 1518, maximum accepted frame length in bytes (dst MAC through FCS).
REQ-004 rx_clk  input  1  receive byte clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 rx_dv  input  1  GMII receive data valid.
REQ-007 rxd  input  8  GMII receive byte.
REQ-008 ip_pkt_end  output  1  one-cycle pulse, good frame addressed to this station ended.
REQ-009 ip_prot_type  output  16  EtherType of the current or last frame, big-endian (byte 12 = [15:8]).
REQ-010 src_mac  output  48  source MAC of the current or last frame, byte 6 = [47:40].
REQ-011 frame_err  output  1  one-cycle pulse, frame dropped (CRC, length, or bad SFD).

Function
REQ-012 FSM states IDLE, PREAMBLE, BODY, DROP; encoding free; all outputs registered.
REQ-013 IDLE: rx_dv=1 and rxd=8'h55 -> PREAMBLE; rx_dv=1 and other rxd -> DROP; else stay.
REQ-014 PREAMBLE: rx_dv=1, rxd=8'h55 -> stay; rxd=8'hd5 -> BODY; other rxd -> DROP with frame_err pulse; rx_dv=0 -> IDLE, no pulse.
REQ-015 PREAMBLE: more than 7 consecutive 8'h55 bytes before SFD -> DROP with frame_err pulse.
REQ-016 BODY: byte_cnt (11 bits, saturating at 2047, cleared on SFD) counts bytes from dst MAC through FCS.
REQ-017 BODY: bytes 0-5 compared to LOCAL_MAC and to 48'hffffffffffff; dst_ok set if either matches fully.
REQ-018 Bytes 6-11 shifted into src_mac; bytes 12-13 into ip_prot_type; both update as bytes arrive and otherwise hold.
REQ-019 CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over every BODY byte incl. FCS; frame CRC good iff final register = 32'hC704DD7B (residue).
REQ-020 BODY with rx_dv=0: evaluate in that cycle; IDLE next cycle.
REQ-021 Evaluation: good = crc ok and MIN_LEN <= byte_cnt <= MAX_LEN.
REQ-022 Evaluation: good and dst_ok -> ip_pkt_end=1 for exactly the next cycle.
REQ-023 Evaluation: not good -> frame_err=1 for exactly the next cycle.
REQ-024 Evaluation: good but not dst_ok -> neither pulse.
REQ-025 ip_pkt_end latency: asserted in the 2nd rx_clk edge after the last byte with rx_dv=1.
REQ-026 ip_prot_type and src_mac stable from ip_pkt_end assertion until byte 6 of the next frame.
REQ-027 ip_pkt_end and frame_err never asserted in the same cycle.
REQ-028 DROP: ignore rxd; rx_dv=0 -> IDLE; a frame entering DROP never produces ip_pkt_end.
REQ-029 Back-to-back frames with a single rx_dv=0 cycle between them are both parsed; a new preamble in the cycle after evaluation is accepted.

Reset
REQ-030 rst_n=0 sampled at a rising edge -> next state IDLE, ip_pkt_end=0, frame_err=0, ip_prot_type=16'h0, src_mac=48'h0, byte_cnt=0, CRC=32'hFFFFFFFF.
REQ-031 Reset mid-frame aborts with no pulse; the rest of that frame is discarded via DROP (rx_dv still high on exit from reset -> DROP).

Verification
REQ-032 7x55, d5, 64-byte broadcast ARP (type 0806, valid FCS) -> ip_pkt_end one cycle, ip_prot_type=16'h0806, src_mac matches, frame_err=0.
REQ-033 Same frame with one payload bit flipped -> frame_err one cycle, ip_pkt_end=0.
REQ-034 Valid 64-byte frame to dst 00:11:22:33:44:55 -> no pulses; ip_prot_type still updated.
REQ-035 60-byte frame with correct FCS to LOCAL_MAC -> frame_err (short); 1519-byte frame -> frame_err (long).
REQ-036 Preamble 55,55,aa -> frame_err, remainder ignored; then a valid frame after one idle cycle -> ip_pkt_end.
REQ-037 rst_n low for 1 cycle at byte 20 of valid frame -> no pulses for that frame; next valid frame -> ip_pkt_end.
